multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit_if.sv | 32 +++
 rtl/multicycle_control_unit.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Handshake and control bundle between the multicycle control unit and its datapath/driver.
interface multicycle_control_unit_if #(
  parameter int ALU_OP_W = 4
);
  logic                instr_valid;
  logic [31:0]         instr;
  logic                instr_ready;
  logic                mem_ready;
  logic                branch_taken;
  logic                reg_write;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_src_imm;
  logic                mem_read;
  logic                mem_write;
  logic                pc_write;
  logic                pc_src;
  logic                illegal;
  logic                mem_err;
  logic [2:0]          state;

  modport master (
    output instr_valid, instr, mem_ready, branch_taken,
    input  instr_ready, reg_write, alu_op, alu_src_imm, mem_read, mem_write,
           pc_write, pc_src, illegal, mem_err, state
  );

  modport slave (
    input  instr_valid, instr, mem_ready, branch_taken,
    output instr_ready, reg_write, alu_op, alu_src_imm, mem_read, mem_write,
           pc_write, pc_src, illegal, mem_err, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V subset control FSM: IDLE -> DECODE -> EXECUTE -> [MEM] -> [WB] -> IDLE.
// Outputs are registered and set on the transition into the cycle they belong to;
// only pc_src in a branch EXECUTE cycle passes branch_taken straight through.
// Pulses that depend on mem_ready (store pc_write, mem_err) land in the first IDLE cycle.
module multicycle_control_unit #(
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int ENABLE_JAL  = 1
) (
  input  logic clk,
  input  logic rst,
  multicycle_control_unit_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR   = 4'd3, A_XOR = 4'd4;
  localparam logic [3:0] A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_SLT  = 4'd8, A_SLTU = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_t;

  state_t           st;
  logic [31:0]      ir;
  logic [CNT_W-1:0] wait_cnt;
  logic             instr_ready_q, reg_write_q, alu_src_q, mem_read_q, mem_write_q;
  logic             pc_write_q, pc_src_q, br_q, illegal_q, mem_err_q;
  logic [3:0]       alu_op_q;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LD, OP_ST, OP_BR: return 1'b1;
      OP_JAL:                          return (ENABLE_JAL != 0);
      default:                         return 1'b0;
    endcase
  endfunction

  // Illegal opcodes fall into the default arm and decode to ADD (0).
  function automatic logic [3:0] alu_dec(input logic [31:0] i);
    logic [3:0] base;
    base = A_ADD;
    case (i[14:12])
      3'b000: base = (i[6:0] == OP_R && i[30]) ? A_SUB : A_ADD;
      3'b001: base = A_SLL;
      3'b010: base = A_SLT;
      3'b011: base = A_SLTU;
      3'b100: base = A_XOR;
      3'b101: base = i[30] ? A_SRA : A_SRL;
      3'b110: base = A_OR;
      default: base = A_AND;
    endcase
    case (i[6:0])
      OP_R, OP_I: return base;
      OP_BR:      return A_SUB;
      default:    return A_ADD;
    endcase
  endfunction

  function automatic logic src_dec(input logic [6:0] op);
    return is_legal(op) && (op != OP_R) && (op != OP_BR);
  endfunction

  // State, captured instruction, wait counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= S_IDLE;
      ir            <= '0;
      wait_cnt      <= '0;
      instr_ready_q <= 1'b1;
      reg_write_q   <= 1'b0;
      alu_op_q      <= '0;
      alu_src_q     <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      pc_write_q    <= 1'b0;
      pc_src_q      <= 1'b0;
      br_q          <= 1'b0;
      illegal_q     <= 1'b0;
      mem_err_q     <= 1'b0;
    end else begin
      illegal_q   <= 1'b0;
      mem_err_q   <= 1'b0;
      pc_write_q  <= 1'b0;
      reg_write_q <= 1'b0;
      pc_src_q    <= 1'b0;
      br_q        <= 1'b0;
      case (st)
        S_IDLE: begin
          if (bus.instr_valid && instr_ready_q) begin
            ir            <= bus.instr;
            st            <= S_DECODE;
            instr_ready_q <= 1'b0;
            alu_op_q      <= alu_dec(bus.instr);
            alu_src_q     <= src_dec(bus.instr[6:0]);
            illegal_q     <= !is_legal(bus.instr[6:0]);
          end
        end
        S_DECODE: begin
          if (!is_legal(ir[6:0])) begin
            st            <= S_IDLE;
            instr_ready_q <= 1'b1;
            alu_op_q      <= '0;
            alu_src_q     <= 1'b0;
          end else begin
            st <= S_EXECUTE;
            if (ir[6:0] == OP_BR) begin
              pc_write_q <= 1'b1;
              br_q       <= 1'b1;
            end
          end
        end
        S_EXECUTE: begin
          case (ir[6:0])
            OP_BR: begin
              st            <= S_IDLE;
              instr_ready_q <= 1'b1;
              alu_op_q      <= '0;
              alu_src_q     <= 1'b0;
            end
            OP_LD, OP_ST: begin
              st          <= S_MEM;
              wait_cnt    <= '0;
              mem_read_q  <= (ir[6:0] == OP_LD);
              mem_write_q <= (ir[6:0] == OP_ST);
            end
            default: begin
              st          <= S_WB;
              reg_write_q <= 1'b1;
              pc_write_q  <= 1'b1;
              pc_src_q    <= (ir[6:0] == OP_JAL);
            end
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            pc_write_q  <= 1'b1;
            if (ir[6:0] == OP_LD) begin
              st          <= S_WB;
              reg_write_q <= 1'b1;
            end else begin
              st            <= S_IDLE;
              instr_ready_q <= 1'b1;
              alu_op_q      <= '0;
              alu_src_q     <= 1'b0;
            end
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_err_q     <= 1'b1;
            st            <= S_IDLE;
            instr_ready_q <= 1'b1;
            alu_op_q      <= '0;
            alu_src_q     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          // WB completes here; unused encodings also land back in IDLE.
          st            <= S_IDLE;
          instr_ready_q <= 1'b1;
          alu_op_q      <= '0;
          alu_src_q     <= 1'b0;
          mem_read_q    <= 1'b0;
          mem_write_q   <= 1'b0;
        end
      endcase
    end
  end

  logic unused_ir;
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  assign bus.instr_ready = instr_ready_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.alu_op      = ALU_OP_W'(alu_op_q);
  assign bus.alu_src_imm = alu_src_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.pc_write    = pc_write_q;
  assign bus.pc_src      = br_q ? bus.branch_taken : pc_src_q;
  assign bus.illegal     = illegal_q;
  assign bus.mem_err     = mem_err_q;
  assign bus.state       = st;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed vector table, per-cycle trace model, random instructions,
// reset-in-MEM and an ENABLE_JAL=0 / MEM_TIMEOUT=4 instance.
module tb_multicycle_control_unit;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALU_OP_W(4)) b1 ();
  multicycle_control_unit_if #(.ALU_OP_W(4)) b2 ();

  multicycle_control_unit #(.ALU_OP_W(4), .MEM_TIMEOUT(TMO), .ENABLE_JAL(1)) dut (
    .clk(clk), .rst(rst), .bus(b1));
  multicycle_control_unit #(.ALU_OP_W(4), .MEM_TIMEOUT(4), .ENABLE_JAL(0)) dut2 (
    .clk(clk), .rst(rst), .bus(b2));

  typedef struct packed {
    logic [2:0] st;
    logic       irdy, rw;
    logic [3:0] aop;
    logic       src, mrd, mwr, pcw, pcs, ill, merr;
  } out_t;

  typedef struct {
    out_t o;
    logic mrdy;
  } step_t;

  typedef struct {
    string       nm;
    logic [31:0] ins;
    int          waits;
    bit          taken;
    logic [3:0]  aop;
    bit          src;
    int          lat, rw, pw, ill, me, mcyc;
  } vec_t;

  int n_chk = 0, n_pass = 0;
  step_t tr[$];
  vec_t  vq[$];
  int o_lat, o_rw, o_pw, o_ill, o_me, o_mcyc;
  logic [3:0] o_aop;
  logic o_src;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic out_t smp();
    out_t o;
    o.st = b1.state; o.irdy = b1.instr_ready; o.rw = b1.reg_write; o.aop = b1.alu_op;
    o.src = b1.alu_src_imm; o.mrd = b1.mem_read; o.mwr = b1.mem_write; o.pcw = b1.pc_write;
    o.pcs = b1.pc_src; o.ill = b1.illegal; o.merr = b1.mem_err;
    return o;
  endfunction

  function automatic out_t idle_rec();
    out_t o;
    o = '0;
    o.irdy = 1'b1;
    return o;
  endfunction

  task automatic push(input out_t o, input logic mrdy);
    step_t s;
    s.o = o; s.mrdy = mrdy;
    tr.push_back(s);
  endtask

  // Reference: expected output for every cycle after acceptance, from the instruction-class rules.
  task automatic build(input logic [31:0] ins, input int waits, input bit taken);
    logic [3:0] base [8];
    int kind;     // 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 illegal
    logic [3:0] aop;
    bit src;
    out_t o, idl;
    base = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    case (ins[6:0])
      7'h33: kind = 0;  7'h13: kind = 1;  7'h03: kind = 2;  7'h23: kind = 3;
      7'h63: kind = 4;  7'h6F: kind = 5;  default: kind = 6;
    endcase
    aop = 4'd0; src = 1'b0;
    if (kind <= 1) begin
      aop = base[ins[14:12]];
      if (ins[30] && ins[14:12] == 3'd5) aop = 4'd7;
      if (kind == 0 && ins[30] && ins[14:12] == 3'd0) aop = 4'd1;
    end
    if (kind == 4) aop = 4'd1;
    src = (kind >= 1 && kind <= 5 && kind != 4);
    idl = idle_rec();
    o = '0; o.st = 3'd1; o.aop = aop; o.src = src; o.ill = (kind == 6);
    push(o, 1'b0);
    if (kind == 6) begin push(idl, 1'b0); return; end
    o = '0; o.st = 3'd2; o.aop = aop; o.src = src;
    if (kind == 4) begin o.pcw = 1'b1; o.pcs = taken; end
    push(o, 1'b0);
    if (kind == 4) begin push(idl, 1'b0); return; end
    if (kind == 2 || kind == 3) begin
      for (int j = 0; j < TMO; j++) begin
        o = '0; o.st = 3'd3; o.aop = aop; o.src = src; o.mrd = (kind == 2); o.mwr = (kind == 3);
        push(o, j == waits);
        if (j == waits) begin
          if (kind == 3) begin
            idl.pcw = 1'b1;
            push(idl, 1'b0);
            return;
          end
          break;
        end
        if (j == TMO - 1) begin
          idl.merr = 1'b1;
          push(idl, 1'b0);
          return;
        end
      end
    end
    o = '0; o.st = 3'd4; o.aop = aop; o.src = src; o.rw = 1'b1; o.pcw = 1'b1; o.pcs = (kind == 5);
    push(o, 1'b0);
    push(idl, 1'b0);
  endtask

  // Offer one instruction to dut and compare every following cycle against the model trace.
  task automatic run(input string nm, input logic [31:0] ins, input int waits, input bit taken);
    out_t o;
    tr.delete();
    build(ins, waits, taken);
    o_lat = 0; o_rw = 0; o_pw = 0; o_ill = 0; o_me = 0; o_mcyc = 0; o_aop = 'x; o_src = 1'bx;
    b1.branch_taken = taken; b1.instr = ins; b1.instr_valid = 1'b1; b1.mem_ready = 1'b0;
    @(posedge clk); #1;
    b1.instr_valid = 1'b0; b1.instr = $urandom;
    for (int i = 0; i < tr.size(); i++) begin
      b1.mem_ready = tr[i].mrdy;
      @(negedge clk);
      o = smp();
      chk($sformatf("%s cyc%0d", nm, i), 32'(o), 32'(tr[i].o));
      if (i == 0) begin o_aop = o.aop; o_src = o.src; end
      o_rw += o.rw; o_pw += o.pcw; o_ill += o.ill; o_me += o.merr; o_mcyc += (o.mrd | o.mwr);
      if (o.st == 3'd0 && o_lat == 0) o_lat = i + 1;
      if (i < tr.size() - 1) begin @(posedge clk); #1; end
    end
    b1.mem_ready = 1'b0;
  endtask

  task automatic addv(input string nm, input logic [31:0] ins, input int waits, input bit taken,
                      input logic [3:0] aop, input bit src, input int lat, input int rw,
                      input int pw, input int ill, input int me, input int mcyc);
    vec_t v;
    v.nm = nm; v.ins = ins; v.waits = waits; v.taken = taken; v.aop = aop; v.src = src;
    v.lat = lat; v.rw = rw; v.pw = pw; v.ill = ill; v.me = me; v.mcyc = mcyc;
    vq.push_back(v);
  endtask

  initial begin
    logic [6:0] ops [8];
    int cnt_mw, cnt_me, cnt_pw;
    bit seen;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h7F, 7'h37};

    //   name        instr         wt tk aop src lat rw pw ill me mcyc
    addv("add",      32'h002081B3, 0, 0, 0, 0,  4, 1, 1, 0, 0, 0);
    addv("sub",      32'h402081B3, 0, 1, 1, 0,  4, 1, 1, 0, 0, 0);
    addv("srai",     32'h4020D093, 0, 0, 7, 1,  4, 1, 1, 0, 0, 0);
    addv("addi_b30", 32'h40000093, 0, 0, 0, 1,  4, 1, 1, 0, 0, 0);
    addv("sltu",     32'h0020B1B3, 0, 0, 9, 0,  4, 1, 1, 0, 0, 0);
    addv("srl",      32'h0020D1B3, 0, 0, 6, 0,  4, 1, 1, 0, 0, 0);
    addv("andi",     32'h0FF0F093, 0, 0, 2, 1,  4, 1, 1, 0, 0, 0);
    addv("lw_w3",    32'h00012083, 3, 0, 0, 1,  8, 1, 1, 0, 0, 4);
    addv("sw_w0",    32'h00112023, 0, 0, 0, 1,  4, 0, 1, 0, 0, 1);
    addv("beq_t",    32'h00208463, 0, 1, 1, 0,  3, 0, 1, 0, 0, 0);
    addv("beq_nt",   32'h00208463, 0, 0, 1, 0,  3, 0, 1, 0, 0, 0);
    addv("jal",      32'h008000EF, 0, 0, 0, 1,  4, 1, 1, 0, 0, 0);
    addv("sw_tmo",   32'h00112023, 20, 0, 0, 1, 19, 0, 0, 0, 1, 16);
    addv("sw_w16",   32'h00112023, 16, 0, 0, 1, 19, 0, 0, 0, 1, 16);
    addv("sw_w15",   32'h00112023, 15, 0, 0, 1, 19, 0, 1, 0, 0, 16);
    addv("lw_w15",   32'h00012083, 15, 0, 0, 1, 20, 1, 1, 0, 0, 16);
    addv("ill_7f",   32'h0000007F, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0);

    b1.instr_valid = 1'b0; b1.instr = '0; b1.mem_ready = 1'b0; b1.branch_taken = 1'b0;
    b2.instr_valid = 1'b0; b2.instr = '0; b2.mem_ready = 1'b0; b2.branch_taken = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", 32'(smp()), 32'(idle_rec()));
    chk("reset dut2", {b2.state, b2.instr_ready, b2.illegal, b2.pc_write}, {3'd0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post-reset idle", 32'(smp()), 32'(idle_rec()));

    // Directed table
    foreach (vq[k]) begin
      run(vq[k].nm, vq[k].ins, vq[k].waits, vq[k].taken);
      chk({vq[k].nm, " aop"},  o_aop,  vq[k].aop);
      chk({vq[k].nm, " src"},  o_src,  vq[k].src);
      chk({vq[k].nm, " lat"},  o_lat,  vq[k].lat);
      chk({vq[k].nm, " rw"},   o_rw,   vq[k].rw);
      chk({vq[k].nm, " pw"},   o_pw,   vq[k].pw);
      chk({vq[k].nm, " ill"},  o_ill,  vq[k].ill);
      chk({vq[k].nm, " me"},   o_me,   vq[k].me);
      chk({vq[k].nm, " mcyc"}, o_mcyc, vq[k].mcyc);
    end

    // Random instructions against the trace model
    for (int r = 0; r < 40; r++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 7)];
      run($sformatf("rnd%0d_%h", r, ins), ins, $urandom_range(0, 18), 1'($urandom));
    end

    // Reset while waiting in MEM
    b1.instr = 32'h00012083; b1.instr_valid = 1'b1; b1.mem_ready = 1'b0;
    @(posedge clk); #1 b1.instr_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (b1.state == 3'd3) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("reach MEM", seen, 1'b1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("reset in MEM", 32'(smp()), 32'(idle_rec()));
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("after reset %0d", c), 32'(smp()), 32'(idle_rec()));
    end

    // ENABLE_JAL=0: JAL is illegal
    b2.instr = 32'h008000EF; b2.instr_valid = 1'b1;
    @(posedge clk); #1 b2.instr_valid = 1'b0;
    @(negedge clk);
    chk("jal off decode", {b2.state, b2.illegal, b2.reg_write, b2.pc_write}, {3'd1, 1'b1, 1'b0, 1'b0});
    @(posedge clk); @(negedge clk);
    chk("jal off idle", {b2.state, b2.illegal, b2.instr_ready}, {3'd0, 1'b0, 1'b1});

    // MEM_TIMEOUT=4 store abort
    b2.instr = 32'h00112023; b2.instr_valid = 1'b1; b2.mem_ready = 1'b0;
    @(posedge clk); #1 b2.instr_valid = 1'b0;
    cnt_mw = 0; cnt_me = 0; cnt_pw = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      cnt_mw += b2.mem_write; cnt_me += b2.mem_err; cnt_pw += b2.pc_write;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("tmo4 mem_write cycles", cnt_mw, 4);
    chk("tmo4 mem_err pulses", cnt_me, 1);
    chk("tmo4 pc_write", cnt_pw, 0);
    chk("tmo4 idle", {b2.state, b2.instr_ready}, {3'd0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
